// File: rtl/matmul_apb_master_if.sv
// matmul_apb_master_if: command/response channels plus APB bus of the matmul APB initiator.
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : single read/write command channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout : response channel
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB requester bus
// Modports: master = the initiator (matmul_apb_master), slave = command source plus APB completer.
interface matmul_apb_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int BUS_WIDTH  = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [BUS_WIDTH-1:0]  cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [BUS_WIDTH-1:0]  rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [BUS_WIDTH-1:0]  pwdata;
    logic [BUS_WIDTH-1:0]  prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/matmul_apb_master.sv
// matmul_apb_master: APB initiator turning single valid/ready commands into APB SETUP/ACCESS transfers.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : matmul_apb_master_if.master (command channel, response channel, APB requester bus)
// Optional: define MATMUL_APB_TIMEOUT_EN to end an ACCESS phase after TIMEOUT_CYCLES wait cycles
// with rsp_err = rsp_timeout = 1; otherwise ACCESS waits indefinitely and rsp_timeout is 0.
module matmul_apb_master #(
    parameter int DATA_WIDTH     = 16,
    parameter int BUS_WIDTH      = 64,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    matmul_apb_master_if.master   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // A bus narrower than one element or a zero timeout is a configuration error.
    if (BUS_WIDTH < DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("matmul_apb_master: invalid BUS_WIDTH/DATA_WIDTH/TIMEOUT_CYCLES");
    end

    logic [1:0]            state;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [BUS_WIDTH-1:0]  pwdata_q;
    logic [BUS_WIDTH-1:0]  rdata_q;
    logic                  err_q;
    logic                  done;
    logic                  expire;

    // pslverr alone also ends the transfer so a stuck-low pready cannot hang an errored access.
    assign done = (state == ACCESS) && (bus.pready || bus.pslverr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    state    <= SETUP;
                    pwrite_q <= bus.cmd_write;
                    paddr_q  <= bus.cmd_addr;
                    pwdata_q <= bus.cmd_wdata;
                end
                SETUP: state <= ACCESS;
                ACCESS: if (done || expire) begin
                    state   <= RESP;
                    err_q   <= bus.pslverr || expire;
                    rdata_q <= (done && !pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                end
                default: if (bus.rsp_ready) state <= IDLE;
            endcase
        end
    end

`ifdef MATMUL_APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          tmo_q;

    // Expiry fires in the ACCESS cycle that would bring the wait count to TIMEOUT_CYCLES;
    // a completion in that same cycle takes priority.
    assign expire = (state == ACCESS) && !done && (cnt == T_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.cmd_valid)
                cnt <= '0;
            else if (state == ACCESS && !done)
                cnt <= cnt + 1'b1;
            if (done || expire)
                tmo_q <= expire;
        end
    end

    assign bus.rsp_timeout = tmo_q;
`else
    assign expire          = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    // cmd_ready is gated by rst so it reads 0 while reset is held.
    assign bus.cmd_ready = (state == IDLE) && rst;
    assign bus.psel      = (state == SETUP) || (state == ACCESS);
    assign bus.penable   = (state == ACCESS);
    assign bus.rsp_valid = (state == RESP);
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
